// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, plus the upstream stall request.
interface execute_stage_if;
   logic        ewreg;
   logic        em2reg;
   logic        ewmem;
   logic [3:0]  ealuc;
   logic        ealuimm;
   logic [4:0]  edestReg;
   logic [31:0] eqa;
   logic [31:0] eqb;
   logic [31:0] eimm32;
   logic        stall;
   logic        mwreg;
   logic        mm2reg;
   logic        mwmem;
   logic [4:0]  mdestReg;
   logic [31:0] mr;
   logic [31:0] mqb;

   modport master (
      output ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
      input  stall, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
   );

   modport slave (
      input  ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
      output stall, mwreg, mm2reg, mwmem, mdestReg, mr, mqb
   );
endinterface

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU plus a 32-step shift-add multiplier that
// stalls upstream and inserts EX/MEM bubbles until the product is ready.
module execute_stage (
   input logic            clk,
   input logic            resetn,
   execute_stage_if.slave ex
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mul_state_t;

   localparam logic [3:0] OP_MUL = 4'b1010;

   mul_state_t  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q, acc_d;

   logic        mwreg_q, mwreg_d;
   logic        mm2reg_q, mm2reg_d;
   logic        mwmem_q, mwmem_d;
   logic [4:0]  mdest_q, mdest_d;
   logic [31:0] mr_q, mr_d;
   logic [31:0] mqb_q, mqb_d;

   logic [31:0] opb_s;
   logic [31:0] alu_s;
   logic        stall_s;

   assign opb_s = ex.ealuimm ? ex.eimm32 : ex.eqb;

   // Single-cycle ALU; MUL yields 0 here because its result comes from the accumulator
   always_comb begin
      alu_s = 32'd0;
      case (ex.ealuc)
         4'b0000: alu_s = ex.eqa + opb_s;
         4'b0001: alu_s = ex.eqa - opb_s;
         4'b0010: alu_s = ex.eqa & opb_s;
         4'b0011: alu_s = ex.eqa | opb_s;
         4'b0100: alu_s = ex.eqa ^ opb_s;
         4'b0101: alu_s = ex.eqa << opb_s[4:0];
         4'b0110: alu_s = ex.eqa >> opb_s[4:0];
         4'b0111: alu_s = $unsigned($signed(ex.eqa) >>> opb_s[4:0]);
         4'b1000: alu_s = {31'd0, ($signed(ex.eqa) < $signed(opb_s))};
         4'b1001: alu_s = {opb_s[15:0], 16'd0};
         default: alu_s = 32'd0;
      endcase
   end

   // Multiplier FSM next state and EX/MEM next values
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      stall_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ex.ealuc == OP_MUL) begin
               stall_s  = 1'b1;
               state_d  = S_BUSY;
               mcand_d  = ex.eqa;
               mplier_d = opb_s;
               acc_d    = 32'd0;
               cnt_d    = 5'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            stall_s  = 1'b1;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end else begin
               acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_DONE;
            end else begin
               state_d = S_BUSY;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (stall_s) begin
         mwreg_d  = 1'b0;
         mm2reg_d = 1'b0;
         mwmem_d  = 1'b0;
         mdest_d  = 5'd0;
         mr_d     = 32'd0;
         mqb_d    = 32'd0;
      end else begin
         mwreg_d  = ex.ewreg;
         mm2reg_d = ex.em2reg;
         mwmem_d  = ex.ewmem;
         mdest_d  = ex.edestReg;
         mr_d     = (state_q == S_DONE) ? acc_q : alu_s;
         mqb_d    = ex.eqb;
      end
   end

   // State and EX/MEM registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         mcand_q  <= 32'd0;
         mplier_q <= 32'd0;
         acc_q    <= 32'd0;
         mwreg_q  <= 1'b0;
         mm2reg_q <= 1'b0;
         mwmem_q  <= 1'b0;
         mdest_q  <= 5'd0;
         mr_q     <= 32'd0;
         mqb_q    <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         mwreg_q  <= mwreg_d;
         mm2reg_q <= mm2reg_d;
         mwmem_q  <= mwmem_d;
         mdest_q  <= mdest_d;
         mr_q     <= mr_d;
         mqb_q    <= mqb_d;
      end
   end

   // Stall must respond in the same cycle a MUL appears, so it stays combinational
   assign ex.stall    = resetn & stall_s;
   assign ex.mwreg    = mwreg_q;
   assign ex.mm2reg   = mm2reg_q;
   assign ex.mwmem    = mwmem_q;
   assign ex.mdestReg = mdest_q;
   assign ex.mr       = mr_q;
   assign ex.mqb      = mqb_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, MUL latency/bubbles, reset abort.
module tb_execute_stage;
   logic clk;
   logic resetn;
   int   total_cnt;
   int   pass_cnt;

   execute_stage_if ex_if ();

   execute_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .ex     (ex_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctrl(input logic wreg, input logic m2reg, input logic wmem, input logic [4:0] dest);
      ex_if.ewreg    = wreg;
      ex_if.em2reg   = m2reg;
      ex_if.ewmem    = wmem;
      ex_if.edestReg = dest;
   endtask

   task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      ex_if.ealuc   = op;
      ex_if.ealuimm = 1'b0;
      ex_if.eqa     = a;
      ex_if.eqb     = b;
      tick();
      check(tag, ex_if.mr, exp);
   endtask

   // Inputs must already hold the MUL operands; counts stall cycles and checks bubbles
   task automatic run_mul(input string tag, input logic [4:0] dest, input logic [31:0] exp);
      int n;
      int bub_bad;
      n = 0;
      bub_bad = 0;
      while (ex_if.stall && n < 40) begin
         n++;
         tick();
         if (ex_if.mwreg !== 1'b0 || ex_if.mwmem !== 1'b0 || ex_if.mm2reg !== 1'b0 ||
             ex_if.mdestReg !== 5'd0 || ex_if.mr !== 32'd0 || ex_if.mqb !== 32'd0)
            bub_bad++;
      end
      check({tag, "_stall_cycles"}, n, 32'd33);
      check({tag, "_bubbles"}, bub_bad, 32'd0);
      tick();
      check({tag, "_mr"}, ex_if.mr, exp);
      check({tag, "_mdest"}, {27'd0, ex_if.mdestReg}, {27'd0, dest});
      check({tag, "_mwreg"}, {31'd0, ex_if.mwreg}, {31'd0, 1'b1});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total_cnt = 0;
      pass_cnt  = 0;
      resetn    = 1'b0;
      set_ctrl(1'b1, 1'b1, 1'b1, 5'd7);
      ex_if.ealuc   = 4'b1010;
      ex_if.ealuimm = 1'b0;
      ex_if.eqa     = 32'd3;
      ex_if.eqb     = 32'd4;
      ex_if.eimm32  = 32'd0;
      tick();
      tick();
      check("rst_stall", {31'd0, ex_if.stall}, 32'd0);
      check("rst_mr", ex_if.mr, 32'd0);
      check("rst_ctrl", {ex_if.mwreg, ex_if.mm2reg, ex_if.mwmem, ex_if.mdestReg}, 32'd0);
      check("rst_mqb", ex_if.mqb, 32'd0);

      // ADD
      resetn = 1'b1;
      set_ctrl(1'b1, 1'b0, 1'b0, 5'd3);
      ex_if.ealuc = 4'b0000;
      ex_if.eqa   = 32'd5;
      ex_if.eqb   = 32'd7;
      #1;
      check("add_stall", {31'd0, ex_if.stall}, 32'd0);
      tick();
      check("add_mr", ex_if.mr, 32'd12);
      check("add_mwreg", {31'd0, ex_if.mwreg}, 32'd1);
      check("add_mdest", {27'd0, ex_if.mdestReg}, 32'd3);
      check("add_mqb", ex_if.mqb, 32'd7);

      // Immediate operand with store
      set_ctrl(1'b0, 1'b0, 1'b1, 5'd0);
      ex_if.ealuimm = 1'b1;
      ex_if.eimm32  = 32'hFFFF_FFFC;
      ex_if.eqa     = 32'h0000_0100;
      ex_if.eqb     = 32'h0000_00AA;
      tick();
      check("imm_mr", ex_if.mr, 32'h0000_00FC);
      check("imm_mqb", ex_if.mqb, 32'h0000_00AA);
      check("imm_mwmem", {31'd0, ex_if.mwmem}, 32'd1);
      check("imm_mwreg", {31'd0, ex_if.mwreg}, 32'd0);

      // Shifts by immediate
      set_ctrl(1'b1, 1'b1, 1'b0, 5'd12);
      ex_if.eimm32 = 32'd4;
      ex_if.eqa    = 32'h8000_0000;
      ex_if.ealuc  = 4'b0111;
      tick();
      check("sra_mr", ex_if.mr, 32'hF800_0000);
      check("load_mm2reg", {31'd0, ex_if.mm2reg}, 32'd1);
      ex_if.ealuc = 4'b0110;
      tick();
      check("srl_mr", ex_if.mr, 32'h0800_0000);
      ex_if.ealuc = 4'b0101;
      ex_if.eqa   = 32'd3;
      tick();
      check("sll_mr", ex_if.mr, 32'h0000_0030);

      // Register-operand ALU vectors
      set_ctrl(1'b1, 1'b0, 1'b0, 5'd1);
      alu_vec("slt_neg", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_vec("slt_pos", 4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd0);
      alu_vec("sub_wrap", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE);
      alu_vec("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_vec("and", 4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      alu_vec("or", 4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
      alu_vec("xor", 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
      alu_vec("lui", 4'b1001, 32'h0000_0000, 32'hABCD_1234, 32'h1234_0000);
      alu_vec("undef", 4'b1111, 32'h1234_5678, 32'h1111_1111, 32'd0);

      // MUL basic
      set_ctrl(1'b1, 1'b0, 1'b0, 5'd9);
      ex_if.ealuc   = 4'b1010;
      ex_if.ealuimm = 1'b0;
      ex_if.eqa     = 32'h0001_2345;
      ex_if.eqb     = 32'h0000_0100;
      #1;
      check("mul_stall_comb", {31'd0, ex_if.stall}, 32'd1);
      run_mul("mul1", 5'd9, 32'h0123_4500);

      // MUL overflow, then back-to-back MUL 3*3
      set_ctrl(1'b1, 1'b0, 1'b0, 5'd4);
      ex_if.eqa = 32'hFFFF_FFFF;
      ex_if.eqb = 32'd2;
      #1;
      run_mul("mul_ovf", 5'd4, 32'hFFFF_FFFE);
      set_ctrl(1'b1, 1'b0, 1'b0, 5'd5);
      ex_if.eqa = 32'd3;
      ex_if.eqb = 32'd3;
      #1;
      check("b2b_stall", {31'd0, ex_if.stall}, 32'd1);
      run_mul("mul_b2b", 5'd5, 32'd9);

      // Reset with counter at 10 aborts the MUL, which then restarts
      set_ctrl(1'b1, 1'b0, 1'b0, 5'd6);
      ex_if.eqa = 32'd6;
      ex_if.eqb = 32'd7;
      repeat (11) tick();
      check("mid_stall", {31'd0, ex_if.stall}, 32'd1);
      resetn = 1'b0;
      #1;
      check("mid_rst_stall_comb", {31'd0, ex_if.stall}, 32'd0);
      tick();
      check("mid_rst_mr", ex_if.mr, 32'd0);
      check("mid_rst_ctrl", {ex_if.mwreg, ex_if.mm2reg, ex_if.mwmem, ex_if.mdestReg}, 32'd0);
      check("mid_rst_stall", {31'd0, ex_if.stall}, 32'd0);
      resetn = 1'b1;
      #1;
      run_mul("mul_restart", 5'd6, 32'd42);

      // Reset while DONE writes no result
      repeat (33) tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      ex_if.ealuc = 4'b0000;
      check("done_rst_mr", ex_if.mr, 32'd0);
      check("done_rst_mwreg", {31'd0, ex_if.mwreg}, 32'd0);
      tick();
      check("post_rst_add", ex_if.mr, 32'd13);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL provide ports, clock and reset first:
  clk  in  1  rising-edge clock for all state
  resetn  in  1  synchronous active-low reset, sampled on rising clk
  ewreg  in  1  ID/EX register-write enable
  em2reg  in  1  ID/EX select-memory-for-writeback
  ewmem  in  1  ID/EX memory-write enable
  ealuc  in  4  ID/EX ALU operation code
  ealuimm  in  1  ID/EX select eimm32 as ALU operand B
  edestReg  in  5  ID/EX destination register number
  eqa  in  32  ID/EX operand A
  eqb  in  32  ID/EX register operand B
  eimm32  in  32  ID/EX sign-extended immediate
  stall  out  1  hold request to upstream (PC, IF/ID, ID/EX freeze while 1)
  mwreg  out  1  EX/MEM register-write enable
  mm2reg  out  1  EX/MEM memory-to-register select
  mwmem  out  1  EX/MEM memory-write enable
  mdestReg  out  5  EX/MEM destination register
  mr  out  32  EX/MEM ALU result
  mqb  out  32  EX/MEM store data (= eqb)
REQ-002 SHALL use one clock and a synchronous, active-low reset (resetn); no asynchronous logic.

Function
REQ-003 SHALL form operand B = ealuimm ? eimm32 : eqb.
REQ-004 SHALL decode ealuc: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL by B[4:0], 0110 SRL by B[4:0], 0111 SRA by B[4:0], 1000 SLT signed (result 1 or 0), 1001 LUI (B<<16), 1010 MUL (multi-cycle), all others result 0.
REQ-005 SHALL compute ADD/SUB modulo 2^32 with no overflow flag or trap.
REQ-006 Non-MUL ops SHALL be single-cycle: stall=0 and EX/MEM outputs load {ewreg, em2reg, ewmem, edestReg, ALU result, eqb} on the same rising edge.
REQ-007 SHALL implement MUL FSM with states IDLE, BUSY, DONE and a 5-bit iteration counter.
REQ-008 IDLE with ealuc=1010: stall=1 combinationally; on edge load multiplicand=eqa, multiplier=B, product accumulator=0, counter=0, go BUSY.
REQ-009 BUSY: stall=1; each edge perform one shift-add step (accumulator += multiplicand if multiplier[0]; multiplicand<<=1; multiplier>>=1), counter+1; after the step with counter=31, go DONE.
REQ-010 DONE: stall=0; on edge EX/MEM loads control fields from ID/EX and mr = low 32 bits of product; FSM returns to IDLE.
REQ-011 MUL SHALL therefore hold stall high for exactly 33 cycles and deliver mr on the 34th rising edge after MUL first appears.
REQ-012 While stall=1, EX/MEM SHALL load a bubble on every edge: mwreg=mwmem=mm2reg=0, mdestReg=0, mr=0, mqb=0.
REQ-013 Back-to-back MUL: the second MUL, presented after the DONE edge, SHALL be accepted from IDLE with no extra idle cycle.
REQ-014 Product SHALL be the unsigned low 32 bits (identical to signed low 32 bits); upper bits discarded.
REQ-015 ealuc changing mid-BUSY is illegal (upstream frozen); FSM SHALL ignore inputs until DONE.

Reset
REQ-016 resetn=0 at a rising edge SHALL clear mwreg, mm2reg, mwmem, mdestReg, mr, mqb to 0, FSM to IDLE, counter and multiplier datapath to 0.
REQ-017 stall SHALL be forced 0 while resetn=0.
REQ-018 Reset during BUSY or DONE SHALL abort the MUL with no result written; after release a MUL still on inputs SHALL restart from IDLE.

Verification
REQ-019 ADD: eqa=5, eqb=7, ealuimm=0, ealuc=0000, ewreg=1, edestReg=3 -> next edge mr=12, mwreg=1, mdestReg=3, stall=0.
REQ-020 Immediate/store: ealuimm=1, eimm32=0xFFFFFFFC, eqa=0x100, eqb=0xAA, ealuc=0000, ewmem=1 -> mr=0xFC, mqb=0xAA, mwmem=1.
REQ-021 Shift/SLT: eqa=0x80000000, B=4, ealuc=0111 -> mr=0xF8000000; ealuc=1000 with eqa=-1, eqb=1 -> mr=1.
REQ-022 MUL: eqa=0x12345, eqb=0x100, ealuc=1010, edestReg=9 -> stall high 33 cycles, bubbles in EX/MEM, then mr=0x01234500, mdestReg=9, stall=0.
REQ-023 MUL overflow: eqa=0xFFFFFFFF, eqb=2 -> mr=0xFFFFFFFE; immediately followed by MUL 3*3 -> mr=9 after another 34 cycles.
REQ-024 Reset mid-MUL: resetn=0 at BUSY counter=10 -> next edge all outputs 0, stall=0; release -> MUL restarts, 34-cycle latency.
